// File: rtl/matrix_bus_if.sv
// Bus between a matrix-coprocessor initiator and its responder.
// The initiator uses the master modport and the responder uses the slave modport.
interface matrix_bus_if;
    logic [255:0] bus_data_out;
    logic         bus_en;
    logic         bus_rw;
    logic         bus_sel;
    logic         bus_add1sub0;
    logic [255:0] bus_data_in;
    logic         bus_flag;

    modport master (
        output bus_data_out, bus_en, bus_rw, bus_sel, bus_add1sub0,
        input  bus_data_in, bus_flag
    );

    modport slave (
        input  bus_data_out, bus_en, bus_rw, bus_sel, bus_add1sub0,
        output bus_data_in, bus_flag
    );
endinterface

// File: rtl/matrix_bus_initiator.sv
// Initiator for the 256-bit matrix bus. One command runs load A (optional), load B,
// then a result read, and ends with a one-cycle done pulse. Every output is registered.
module matrix_bus_initiator #(
    parameter int ACK_MODE  = 0,
    parameter int FIXED_LAT = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_add,
    input  logic         reuse_a,
    input  logic [255:0] mat_a,
    input  logic [255:0] mat_b,
    output logic [255:0] result,
    output logic         done,
    output logic         busy,
    output logic         err,
    matrix_bus_if.master bus
);

    localparam bit FLAG_MODE = (ACK_MODE == 0);
    localparam int WAIT_LIM  = FLAG_MODE ? TIMEOUT : FIXED_LAT;
    localparam int CW        = $clog2(WAIT_LIM + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ISSUE_A = 4'd1,
        S_WAIT_A  = 4'd2,
        S_ISSUE_B = 4'd3,
        S_WAIT_B  = 4'd4,
        S_ISSUE_R = 4'd5,
        S_WAIT_R  = 4'd6,
        S_CAPTURE = 4'd7,
        S_FINISH  = 4'd8
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [255:0]  a_r, a_nxt_s, b_r, b_nxt_s;
    logic          op_r, op_nxt_s;
    logic [255:0]  result_r, result_nxt_s;
    logic          done_r, done_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          err_r, err_nxt_s;
    logic [255:0]  dout_r, dout_nxt_s;
    logic          en_r, en_nxt_s;
    logic          rw_r, rw_nxt_s;
    logic          sel_r, sel_nxt_s;
    logic          add_r, add_nxt_s;

    function automatic state_t phase_after(input state_t s);
        case (s)
            S_WAIT_A: phase_after = S_ISSUE_B;
            S_WAIT_B: phase_after = S_ISSUE_R;
            S_WAIT_R: phase_after = S_CAPTURE;
            default:  phase_after = S_IDLE;
        endcase
    endfunction

    // Next-state and next-output decode; outputs are computed one cycle ahead of the pins.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        op_nxt_s     = op_r;
        result_nxt_s = result_r;
        done_nxt_s   = 1'b0;
        busy_nxt_s   = busy_r;
        err_nxt_s    = err_r;
        dout_nxt_s   = dout_r;
        en_nxt_s     = 1'b0;
        rw_nxt_s     = rw_r;
        sel_nxt_s    = sel_r;
        add_nxt_s    = add_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    a_nxt_s     = mat_a;
                    b_nxt_s     = mat_b;
                    op_nxt_s    = op_add;
                    err_nxt_s   = 1'b0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = reuse_a ? S_ISSUE_B : S_ISSUE_A;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE_A: begin
                en_nxt_s    = 1'b1;
                rw_nxt_s    = 1'b1;
                sel_nxt_s   = 1'b0;
                dout_nxt_s  = a_r;
                cnt_nxt_s   = '0;
                state_nxt_s = S_WAIT_A;
            end
            S_ISSUE_B: begin
                en_nxt_s    = 1'b1;
                rw_nxt_s    = 1'b1;
                sel_nxt_s   = 1'b1;
                add_nxt_s   = op_r;
                dout_nxt_s  = b_r;
                cnt_nxt_s   = '0;
                state_nxt_s = S_WAIT_B;
            end
            S_ISSUE_R: begin
                en_nxt_s    = 1'b1;
                rw_nxt_s    = 1'b0;
                cnt_nxt_s   = '0;
                state_nxt_s = S_WAIT_R;
            end
            S_WAIT_A, S_WAIT_B, S_WAIT_R: begin
                // The counter's last value ends the phase: a timeout with the flag, a fixed advance without.
                if (FLAG_MODE && bus.bus_flag) begin
                    state_nxt_s = phase_after(state_r);
                end else if (cnt_r == CNT_LAST) begin
                    if (FLAG_MODE) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = S_FINISH;
                    end else begin
                        state_nxt_s = phase_after(state_r);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            S_CAPTURE: begin
                result_nxt_s = bus.bus_data_in;
                state_nxt_s  = S_FINISH;
            end
            S_FINISH: begin
                done_nxt_s  = 1'b1;
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            dout_r   <= '0;
            en_r     <= 1'b0;
            rw_r     <= 1'b0;
            sel_r    <= 1'b0;
            add_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            op_r     <= op_nxt_s;
            result_r <= result_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
            err_r    <= err_nxt_s;
            dout_r   <= dout_nxt_s;
            en_r     <= en_nxt_s;
            rw_r     <= rw_nxt_s;
            sel_r    <= sel_nxt_s;
            add_r    <= add_nxt_s;
        end
    end

    assign result           = result_r;
    assign done             = done_r;
    assign busy             = busy_r;
    assign err              = err_r;
    assign bus.bus_data_out = dout_r;
    assign bus.bus_en       = en_r;
    assign bus.bus_rw       = rw_r;
    assign bus.bus_sel      = sel_r;
    assign bus.bus_add1sub0 = add_r;

endmodule
